sha1_wb_master: RTL
===================

Name: sha1_wb_master

Overview:
Wishbone initiator that drives one SHA1 accelerator block through its register window. It performs one complete hash job per `start` pulse:
- check the ID register;
- arm the engine;
- stream 16 message words;
- poll for DONE;
- read back the 5 digest words.

It sits between on-chip logic that needs hashes (or a self-test harness) and the SHA1 Wishbone responder, so software polling is not needed.

Parameters:
- BASE_ADDRESS, 32'h30000024, base of the SHA1 responder register window.
- ACK_TIMEOUT, 16, cycles to wait for wbm_ack_i before aborting a transaction.
- POLL_LIMIT, 1024, maximum CTRL_OPS status reads before declaring a poll timeout.

Ports:
- wb_clk_i  in  1  bus clock.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle job request; ignored while busy.
- msg_i  in  512  message block, latched on accepted start; word k = msg_i[32k+31:32k].
- busy  out  1  high from accepted start until done or error.
- done  out  1  level; job completed and digest_o valid; cleared by next accepted start.
- error  out  1  level; job aborted; cleared by next accepted start.
- err_code  out  3  0 none, 1 ack timeout, 2 poll timeout, 3 panic, 4 bad ID.
- digest_o  out  160  digest; read j lands in [32j+31:32j].
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte selects; always 4'hF during a transaction.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_ack_i  in  1  acknowledge.
- wbm_dat_i  in  32  read data.

Behaviour:
- Reset: reset synchronous, active-high; clock wb_clk_i. All outputs 0, FSM in IDLE, counters 0, message buffer 0.
- Reset mid-job: cyc/stb drop at the reset edge; no partial digest is kept.
- Transaction rule:
  - Assert cyc, stb, adr, we, sel and dat together (registered); hold them stable until ack is sampled high.
  - On the edge that samples ack=1, capture wbm_dat_i (reads) and deassert cyc/stb.
  - Enforce one idle cycle with cyc=0 before the next transaction; this is required because the responder acks with a one-cycle pulse and re-arms while stb stays high.
  - Ack timeout: if ack is not seen within ACK_TIMEOUT cycles of stb assertion, drop cyc/stb, set error=1 and err_code=1, go to IDLE.
- FSM states (each bus state = issue, wait ack, gap):
  - IDLE: on start, latch msg_i; clear done, error, err_code and digest_o; set busy=1.
  - CHK_ID: read BASE+0x04. If data is not 32'h53484131, error with code 4.
  - ARM: write 32'h1 to BASE+0x10. This clears the responder's word index and done flag.
  - MSG: 16 writes to BASE+0x08 with words k=0..15 in order. The 16th write starts hashing in the responder.
  - POLL: read BASE+0x10.
    - bit3 (DONE) set: go to DIG.
    - bit2 (PANIC) set: error with code 3. If DONE and PANIC are both set, DONE wins.
    - Otherwise increment poll_cnt. When poll_cnt reaches POLL_LIMIT, error with code 2; else reissue the read after the gap.
  - DIG: 5 reads of BASE+0x14, j=0..4, stored into digest_o slices.
  - FIN: done=1, busy=0, back to IDLE.
- Write data bits not driven by the message are 0. wbm_dat_o is 0 during reads.
- start while busy: ignored, with no effect on the latched message.
- start coincident with the cycle busy falls: ignored; busy is registered, so start must arrive when busy=0.
- Minimum job length with a 1-cycle-ack responder: 23 transactions × 3 cycles plus POLL iterations.

Decomposition:
- Package sha1_wb_pkg holds:
  - register offsets (GET_NR 0x00, GET_ID 0x04, MSG_IN 0x08, MSG_IN_IDX 0x0C, OPS 0x10, DIGEST 0x14);
  - the SHA1 ID constant 32'h53484131;
  - OPS bit positions (ON 0, RESET 1, PANIC 2, DONE 3);
  - the err_code enum;
  - the FSM state enum.
- Sub-module wb_master_port: single-transaction engine with req/we/adr/dat in, rsp_valid/rsp_data/timeout out, owning the cyc/stb/gap/timeout logic. The job FSM sequences calls to it.

Test Plan:
- Happy path: behavioural responder computing real SHA1; msg = "abc" padded (word0=32'h61626380, words1-14=0, word15=32'h00000018), start → 1 ID read, 1 OPS write, 16 MSG writes, polls, 5 digest reads; done=1, error=0, digest_o words equal a9993e36, 4706816a, ba3e2571, 7850c26c, 9cd0d89d in read order.
- Bad ID: responder returns 32'hf00df00d at 0x04 → no writes issued, error=1, err_code=4, busy=0.
- Ack timeout: responder never acks the 5th MSG write → cyc/stb drop exactly ACK_TIMEOUT cycles after stb, err_code=1.
- Poll limit and panic:
  - With POLL_LIMIT=4 and DONE never set → exactly 4 OPS reads, then err_code=2.
  - Separate run, PANIC on 2nd poll → err_code=3.
- Protocol checks: assertions that cyc/stb stay low ≥1 cycle between transactions, sel=4'hF whenever stb=1, and adr/dat stable while stb=1 and ack=0. start pulsed while busy → bus sequence unchanged.
- Reset mid-MSG (after word 7): cyc/stb/busy=0 at the reset edge. A fresh start afterwards completes correctly, beginning with the ID read.

Source files
------------

// File: rtl/sha1_wb_pkg.sv
// sha1_wb_pkg: register map, SHA1 responder constants and job FSM types
package sha1_wb_pkg;
  localparam logic [31:0] REG_GET_NR     = 32'h00;
  localparam logic [31:0] REG_GET_ID     = 32'h04;
  localparam logic [31:0] REG_MSG_IN     = 32'h08;
  localparam logic [31:0] REG_MSG_IN_IDX = 32'h0C;
  localparam logic [31:0] REG_OPS        = 32'h10;
  localparam logic [31:0] REG_DIGEST     = 32'h14;
  localparam logic [31:0] SHA1_ID        = 32'h53484131;
  localparam int OPS_ON    = 0;
  localparam int OPS_RESET = 1;
  localparam int OPS_PANIC = 2;
  localparam int OPS_DONE  = 3;
  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_ACK_TIMEOUT  = 3'd1,
    ERR_POLL_TIMEOUT = 3'd2,
    ERR_PANIC        = 3'd3,
    ERR_BAD_ID       = 3'd4
  } err_code_e;
  typedef enum logic [2:0] {
    S_IDLE, S_CHK_ID, S_ARM, S_MSG, S_POLL, S_DIG, S_FIN
  } state_e;
endpackage

// File: rtl/sha1_wb_master_port.sv
// wb_master_port: one Wishbone transaction per req pulse, with ack timeout and a post-ack idle gap
module wb_master_port #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_dat,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_data,
  output logic        o_timeout,
  output logic        o_cyc,
  output logic        o_stb,
  output logic        o_we,
  output logic [3:0]  o_sel,
  output logic [31:0] o_adr,
  output logic [31:0] o_dat,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_dat
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [TW-1:0] r_cnt;
  logic          r_gap;
  always_ff @(posedge wb_clk_i) begin
    o_rsp_valid <= 1'b0;
    o_timeout   <= 1'b0;
    r_gap       <= 1'b0;
    if (reset) begin
      {o_cyc, o_stb, o_we} <= '0;
      o_sel      <= '0;
      o_adr      <= '0;
      o_dat      <= '0;
      o_rsp_data <= '0;
      r_cnt      <= '0;
    end else if (o_cyc) begin
      if (i_wb_ack || r_cnt == TW'(ACK_TIMEOUT - 1)) begin
        {o_cyc, o_stb, o_we} <= '0;
        o_sel       <= '0;
        o_adr       <= '0;
        o_dat       <= '0;
        r_gap       <= 1'b1;
        o_rsp_valid <= i_wb_ack;
        o_timeout   <= !i_wb_ack;
        o_rsp_data  <= i_wb_ack ? i_wb_dat : o_rsp_data;
      end else
        r_cnt <= r_cnt + 1'b1;
    end else if (i_req && !r_gap) begin
      {o_cyc, o_stb} <= 2'b11;
      o_we  <= i_we;
      o_sel <= 4'hF;
      o_adr <= i_adr;
      o_dat <= i_we ? i_dat : '0;
      r_cnt <= '0;
    end
  end
endmodule

// File: rtl/sha1_wb_master.sv
// sha1_wb_master: Wishbone initiator running one full SHA1 job (ID, arm, 16 words, poll, digest) per start
module sha1_wb_master
  import sha1_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h30000024,
  parameter int          ACK_TIMEOUT  = 16,
  parameter int          POLL_LIMIT   = 1024
) (
  input  logic         wb_clk_i,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] msg_i,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [2:0]   err_code,
  output logic [159:0] digest_o,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [3:0]   wbm_sel_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  input  logic         wbm_ack_i,
  input  logic [31:0]  wbm_dat_i
);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  state_e        r_state;
  err_code_e     r_err;
  logic [511:0]  r_msg;
  logic [3:0]    r_idx;
  logic [PW-1:0] r_poll;
  logic          r_req;
  logic          w_we;
  logic [31:0]   w_off;
  logic [31:0]   w_dat;
  logic          w_rsp_valid;
  logic          w_timeout;
  logic [31:0]   w_rsp_data;
  assign err_code = r_err;
  // Request fields follow the state, so they are settled when the port launches a cycle after r_req
  always_comb begin
    w_we  = r_state == S_ARM || r_state == S_MSG;
    w_off = r_state == S_CHK_ID ? REG_GET_ID :
            (r_state == S_ARM || r_state == S_POLL) ? REG_OPS :
            r_state == S_MSG ? REG_MSG_IN : REG_DIGEST;
    w_dat = r_state == S_ARM ? 32'h1 : r_state == S_MSG ? r_msg[{r_idx, 5'b0} +: 32] : '0;
  end
  wb_master_port #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_port (
    .wb_clk_i    (wb_clk_i),
    .reset       (reset),
    .i_req       (r_req),
    .i_we        (w_we),
    .i_adr       (BASE_ADDRESS + w_off),
    .i_dat       (w_dat),
    .o_rsp_valid (w_rsp_valid),
    .o_rsp_data  (w_rsp_data),
    .o_timeout   (w_timeout),
    .o_cyc       (wbm_cyc_o),
    .o_stb       (wbm_stb_o),
    .o_we        (wbm_we_o),
    .o_sel       (wbm_sel_o),
    .o_adr       (wbm_adr_o),
    .o_dat       (wbm_dat_o),
    .i_wb_ack    (wbm_ack_i),
    .i_wb_dat    (wbm_dat_i)
  );
  always_ff @(posedge wb_clk_i) begin
    r_req <= 1'b0;
    if (reset) begin
      r_state  <= S_IDLE;
      r_err    <= ERR_NONE;
      r_msg    <= '0;
      r_idx    <= '0;
      r_poll   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      digest_o <= '0;
    end else if (w_timeout) begin
      {busy, error} <= 2'b01;
      r_err         <= ERR_ACK_TIMEOUT;
      r_state       <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_msg    <= msg_i;
          {busy, done, error} <= 3'b100;
          r_err    <= ERR_NONE;
          digest_o <= '0;
          r_idx    <= '0;
          r_poll   <= '0;
          r_req    <= 1'b1;
          r_state  <= S_CHK_ID;
        end
        S_CHK_ID: if (w_rsp_valid) begin
          if (w_rsp_data != SHA1_ID) begin
            {busy, error} <= 2'b01;
            r_err         <= ERR_BAD_ID;
            r_state       <= S_IDLE;
          end else begin
            r_req   <= 1'b1;
            r_state <= S_ARM;
          end
        end
        S_ARM: if (w_rsp_valid) begin
          r_req   <= 1'b1;
          r_state <= S_MSG;
        end
        S_MSG: if (w_rsp_valid) begin
          r_req   <= 1'b1;
          r_idx   <= r_idx + 1'b1;
          r_state <= r_idx == 4'd15 ? S_POLL : S_MSG;
        end
        S_POLL: if (w_rsp_valid) begin
          if (w_rsp_data[OPS_DONE]) begin
            r_req   <= 1'b1;
            r_idx   <= '0;
            r_state <= S_DIG;
          end else if (w_rsp_data[OPS_PANIC] || r_poll == PW'(POLL_LIMIT - 1)) begin
            {busy, error} <= 2'b01;
            r_err         <= w_rsp_data[OPS_PANIC] ? ERR_PANIC : ERR_POLL_TIMEOUT;
            r_state       <= S_IDLE;
          end else begin
            r_poll <= r_poll + 1'b1;
            r_req  <= 1'b1;
          end
        end
        S_DIG: if (w_rsp_valid) begin
          digest_o[{r_idx[2:0], 5'b0} +: 32] <= w_rsp_data;
          r_idx   <= r_idx + 1'b1;
          r_req   <= r_idx != 4'd4;
          r_state <= r_idx == 4'd4 ? S_FIN : S_DIG;
        end
        S_FIN: begin
          {busy, done} <= 2'b01;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
